// File: rtl/sdram_ch_arbiter.sv
// sdram_ch_arbiter: fixed-priority scheduler that places refreshes and the six
// user burst requesters (ch1_w .. ch3_r) onto the single SDRAM command port.
// It also owns the auto-refresh timer.
module sdram_ch_arbiter #(
    parameter int ADDR_W     = 21,
    parameter int NUM_W      = 9,
    parameter int REF_PERIOD = 1560
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  init_done,
    input  logic [5:0]            req,
    input  logic [6*ADDR_W-1:0]   req_addr,
    input  logic [6*NUM_W-1:0]    req_num,
    output logic [5:0]            req_ack,
    output logic [5:0]            req_done,
    output logic [5:0]            grant,
    output logic                  cmd_valid,
    output logic [1:0]            cmd_type,
    output logic [ADDR_W-1:0]     cmd_addr,
    output logic [NUM_W-1:0]      cmd_num,
    input  logic                  cmd_ready,
    input  logic                  core_done,
    output logic                  busy,
    output logic                  ref_overrun
);

    localparam int CNT_W = (REF_PERIOD > 1) ? $clog2(REF_PERIOD) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        BUSY  = 2'd2,
        ZERO  = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    ref_cnt_q, ref_cnt_d;
    logic                ref_pend_q, ref_pend_d;
    logic                ref_overrun_q, ref_overrun_d;
    logic [5:0]          grant_q, grant_d;
    logic [5:0]          ack_q, ack_d;
    logic [5:0]          done_q, done_d;
    logic [1:0]          cmd_type_q, cmd_type_d;
    logic [ADDR_W-1:0]   cmd_addr_q, cmd_addr_d;
    logic [NUM_W-1:0]    cmd_num_q, cmd_num_d;

    logic                refWrap;
    logic                refAccept;
    logic                reqFound;
    logic [2:0]          reqIdx;
    logic [ADDR_W-1:0]   selAddr;
    logic [NUM_W-1:0]    selNum;

    // Lowest set request bit wins; walk from bit 5 down so bit 0 overwrites last.
    always_comb begin
        reqFound = 1'b0;
        reqIdx   = 3'd0;
        selAddr  = '0;
        selNum   = '0;
        for (int i = 5; i >= 0; i--) begin
            if (req[i]) begin
                reqFound = 1'b1;
                reqIdx   = 3'(i);
                selAddr  = req_addr[i*ADDR_W +: ADDR_W];
                selNum   = req_num[i*NUM_W +: NUM_W];
            end
        end
    end

    // Refresh timer: free-runs only after init, a wrap raises a pending refresh and
    // a wrap that finds the previous one still unserved flags a sticky overrun.
    always_comb begin
        refWrap   = init_done && (ref_cnt_q == CNT_W'(REF_PERIOD - 1));
        refAccept = (state_q == ISSUE) && cmd_ready && (grant_q == 6'd0);

        ref_cnt_d = ref_cnt_q;
        if (!init_done) begin
            ref_cnt_d = '0;
        end else if (refWrap) begin
            ref_cnt_d = '0;
        end else begin
            ref_cnt_d = ref_cnt_q + CNT_W'(1);
        end

        ref_pend_d = ref_pend_q;
        if (refAccept) begin
            ref_pend_d = 1'b0;
        end
        if (refWrap) begin
            ref_pend_d = 1'b1;
        end

        // A refresh accepted in the wrap cycle is no longer outstanding.
        ref_overrun_d = ref_overrun_q | (refWrap & ref_pend_q & ~refAccept);
    end

    // State register and latched command/handshake registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            ref_cnt_q     <= '0;
            ref_pend_q    <= 1'b0;
            ref_overrun_q <= 1'b0;
            grant_q       <= '0;
            ack_q         <= '0;
            done_q        <= '0;
            cmd_type_q    <= '0;
            cmd_addr_q    <= '0;
            cmd_num_q     <= '0;
        end else begin
            state_q       <= state_d;
            ref_cnt_q     <= ref_cnt_d;
            ref_pend_q    <= ref_pend_d;
            ref_overrun_q <= ref_overrun_d;
            grant_q       <= grant_d;
            ack_q         <= ack_d;
            done_q        <= done_d;
            cmd_type_q    <= cmd_type_d;
            cmd_addr_q    <= cmd_addr_d;
            cmd_num_q     <= cmd_num_d;
        end
    end

    // Next state: arbitrate in IDLE (refresh first), then walk the command handshake.
    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        ack_d      = '0;
        done_d     = '0;
        cmd_type_d = cmd_type_q;
        cmd_addr_d = cmd_addr_q;
        cmd_num_d  = cmd_num_q;

        unique case (state_q)
            IDLE: begin
                if (init_done) begin
                    if (ref_pend_q || refWrap) begin
                        grant_d    = '0;
                        cmd_type_d = 2'd2;
                        cmd_addr_d = '0;
                        cmd_num_d  = '0;
                        state_d    = ISSUE;
                    end else if (reqFound) begin
                        grant_d    = 6'b000001 << reqIdx;
                        cmd_type_d = {1'b0, reqIdx[0]};
                        cmd_addr_d = selAddr;
                        cmd_num_d  = selNum;
                        state_d    = (selNum == '0) ? ZERO : ISSUE;
                    end
                end
            end
            ISSUE: begin
                if (cmd_ready) begin
                    ack_d   = grant_q;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (core_done) begin
                    done_d  = grant_q;
                    grant_d = '0;
                    state_d = IDLE;
                end
            end
            ZERO: begin
                grant_d = '0;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Outputs: zero-length bursts ack and done while still in ZERO so the requester
    // drops its request before IDLE samples it again.
    always_comb begin
        cmd_valid   = (state_q == ISSUE);
        busy        = (state_q != IDLE);
        grant       = grant_q;
        cmd_type    = cmd_type_q;
        cmd_addr    = cmd_addr_q;
        cmd_num     = cmd_num_q;
        ref_overrun = ref_overrun_q;
        req_ack     = ack_q;
        req_done    = done_q;
        if (state_q == ZERO) begin
            req_ack  = ack_q | grant_q;
            req_done = done_q | grant_q;
        end
    end

endmodule
